// File: rtl/cpu_pkg.sv
// Opcode encodings shared with the ALU, plus the writeback push decision.
// has_wb() is true for every opcode that produces a register-file write.
package cpu_pkg;

  localparam logic [4:0] OP_LDW    = 5'b00000;
  localparam logic [4:0] OP_LDWI   = 5'b00001;
  localparam logic [4:0] OP_STW    = 5'b00010;
  localparam logic [4:0] OP_ADD    = 5'b00011;
  localparam logic [4:0] OP_SUB    = 5'b00100;
  localparam logic [4:0] OP_SHR    = 5'b00101;
  localparam logic [4:0] OP_SHL    = 5'b00110;
  localparam logic [4:0] OP_ROR    = 5'b00111;
  localparam logic [4:0] OP_ROL    = 5'b01000;
  localparam logic [4:0] OP_AND    = 5'b01001;
  localparam logic [4:0] OP_OR     = 5'b01010;
  localparam logic [4:0] OP_ADDI   = 5'b01011;
  localparam logic [4:0] OP_ANDI   = 5'b01100;
  localparam logic [4:0] OP_ORI    = 5'b01101;
  localparam logic [4:0] OP_MUL    = 5'b01110;
  localparam logic [4:0] OP_DIV    = 5'b01111;
  localparam logic [4:0] OP_NEG    = 5'b10000;
  localparam logic [4:0] OP_NOT    = 5'b10001;
  localparam logic [4:0] OP_BRANCH = 5'b10010;
  localparam logic [4:0] OP_JR     = 5'b10011;
  localparam logic [4:0] OP_JAL    = 5'b10100;
  localparam logic [4:0] OP_IN     = 5'b10101;
  localparam logic [4:0] OP_OUT    = 5'b10110;
  localparam logic [4:0] OP_MFHI   = 5'b10111;
  localparam logic [4:0] OP_MFLO   = 5'b11000;
  localparam logic [4:0] OP_NOP    = 5'b11001;
  localparam logic [4:0] OP_HALT   = 5'b11010;

  function automatic logic has_wb(input logic [4:0] op);
    case (op)
      OP_LDW, OP_LDWI, OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_NEG, OP_NOT, OP_IN,
      OP_JAL, OP_MFHI, OP_MFLO: has_wb = 1'b1;
      default:                  has_wb = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry strict FIFO; head visible one edge after push into an empty queue.
// Push when full and pop when empty are ignored; no same-cycle bypass.
module wb_fifo2 #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != 2'd2);
    do_pop   = pop && (count_q != 2'd0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == 2'd2);
  assign empty    = (count_q == 2'd0);

endmodule

// File: rtl/alu_writeback.sv
// ALU result stage: Z/HI/LO capture, mfhi/mflo select and a 2-deep writeback queue.
// in_ready comes from registered state only (not halted, queue not full); halt is sticky.
module alu_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          opcode,
  input  logic [2*DATA_W-1:0] rc,
  input  logic [3:0]          in_dest,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [DATA_W-1:0]   wb_data,
  output logic [3:0]          wb_dest,
  output logic [DATA_W-1:0]   hi_out,
  output logic [DATA_W-1:0]   lo_out,
  output logic [2*DATA_W-1:0] z_out,
  output logic                halted
);

  localparam int ENTRY_W = DATA_W + 4;

  logic [2*DATA_W-1:0] z_q, z_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                halted_q, halted_d;

  logic                accept, push, pop;
  logic [DATA_W-1:0]   push_data;
  logic [ENTRY_W-1:0]  head;
  logic                fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count;

  assign in_ready = !halted_q && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign pop      = wb_ready && !fifo_empty;

  // mfhi/mflo read HI/LO as they stood before this accept.
  always_comb begin
    z_d       = z_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    halted_d  = halted_q;
    push      = 1'b0;
    push_data = rc[DATA_W-1:0];
    if (accept) begin
      z_d  = rc;
      push = has_wb(opcode);
      case (opcode)
        OP_MUL, OP_DIV: begin
          hi_d = rc[2*DATA_W-1:DATA_W];
          lo_d = rc[DATA_W-1:0];
        end
        OP_MFHI: push_data = hi_q;
        OP_MFLO: push_data = lo_q;
        OP_HALT: halted_d  = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      z_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      z_q      <= z_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      halted_q <= halted_d;
    end
  end

  wb_fifo2 #(.W(ENTRY_W)) u_fifo (
    .clk      (clk),
    .rst_n    (clear),
    .push     (push),
    .push_dat ({push_data, in_dest}),
    .pop      (pop),
    .head_dat (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign wb_valid = (fifo_count != '0);
  assign wb_data  = head[ENTRY_W-1:4];
  assign wb_dest  = head[3:0];
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign z_out    = z_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed plus randomized bench for alu_writeback against a queue-based reference model.
module tb_alu_writeback;

  logic        clk;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  opcode;
  logic [63:0] rc;
  logic [3:0]  in_dest;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [3:0]  wb_dest;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [63:0] z_out;
  logic        halted;

  alu_writeback #(.DATA_W(32), .FIFO_DEPTH(2)) dut (
    .clk      (clk),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .rc       (rc),
    .in_dest  (in_dest),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_data  (wb_data),
    .wb_dest  (wb_dest),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .z_out    (z_out),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: writeback queue as a plain SV queue of {data, dest}.
  logic [35:0] mq[$];
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_z;
  logic        m_halted;

  localparam logic [4:0] WB_OPS [17] = '{5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                                         5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd16, 5'd17,
                                         5'd20, 5'd21};

  function automatic bit is_wb_op(input logic [4:0] op);
    foreach (WB_OPS[i]) if (WB_OPS[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_hi     = '0;
    m_lo     = '0;
    m_z      = '0;
    m_halted = 1'b0;
  endtask

  task automatic model_step();
    bit acc;
    acc = in_valid && !m_halted && (mq.size() < 2);
    if (wb_ready && mq.size() > 0) void'(mq.pop_front());
    if (acc) begin
      m_z = rc;
      if (opcode == 5'd14 || opcode == 5'd15) begin
        m_hi = rc[63:32];
        m_lo = rc[31:0];
      end else if (opcode == 5'd23) mq.push_back({m_hi, in_dest});
      else if (opcode == 5'd24) mq.push_back({m_lo, in_dest});
      else if (opcode == 5'd26) m_halted = 1'b1;
      else if (is_wb_op(opcode)) mq.push_back({rc[31:0], in_dest});
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " in_ready"}, 64'(in_ready), 64'(!m_halted && (mq.size() < 2)));
    chk({tag, " wb_valid"}, 64'(wb_valid), 64'(mq.size() != 0));
    if (mq.size() > 0) begin
      chk({tag, " wb_data"}, 64'(wb_data), 64'(mq[0][35:4]));
      chk({tag, " wb_dest"}, 64'(wb_dest), 64'(mq[0][3:0]));
    end
    chk({tag, " hi_out"}, 64'(hi_out), 64'(m_hi));
    chk({tag, " lo_out"}, 64'(lo_out), 64'(m_lo));
    chk({tag, " z_out"},  z_out, m_z);
    chk({tag, " halted"}, 64'(halted), 64'(m_halted));
  endtask

  // Check pre-edge outputs at the falling edge, advance the model, then return 1 time unit after the rising edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_all(tag);
    if (!clear) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [63:0] r, input logic [3:0] d, input string tag);
    in_valid = 1'b1;
    opcode   = op;
    rc       = r;
    in_dest  = d;
    cycle(tag);
  endtask

  initial begin
    clear    = 1'b0;
    in_valid = 1'b0;
    opcode   = '0;
    rc       = '0;
    in_dest  = '0;
    wb_ready = 1'b0;
    model_reset();

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom);
      opcode   = 5'($urandom);
      rc       = {$urandom, $urandom};
      in_dest  = 4'($urandom);
      wb_ready = 1'($urandom);
      cycle("reset");
      chk("reset wb_data", 64'(wb_data), 64'd0);
      chk("reset wb_dest", 64'(wb_dest), 64'd0);
      chk("reset z_out", z_out, 64'd0);
    end
    clear    = 1'b1;
    in_valid = 1'b0;
    wb_ready = 1'b1;
    cycle("post_reset");
    chk("post_reset in_ready", 64'(in_ready), 64'd1);

    // Single add, written back and popped.
    issue(5'd3, 64'h0000_0000_0000_0005, 4'd3, "add");
    in_valid = 1'b0;
    chk("add wb_valid", 64'(wb_valid), 64'd1);
    chk("add wb_data", 64'(wb_data), 64'd5);
    chk("add wb_dest", 64'(wb_dest), 64'd3);
    cycle("add_pop");
    chk("add_pop wb_valid", 64'(wb_valid), 64'd0);

    // mul then mfhi/mflo.
    wb_ready = 1'b0;
    issue(5'd14, 64'h0000_0001_0000_0002, 4'd9, "mul");
    chk("mul hi_out", 64'(hi_out), 64'd1);
    chk("mul lo_out", 64'(lo_out), 64'd2);
    chk("mul wb_valid", 64'(wb_valid), 64'd0);
    issue(5'd23, 64'hdead_beef_dead_beef, 4'd4, "mfhi");
    issue(5'd24, 64'hcafe_f00d_cafe_f00d, 4'd5, "mflo");
    in_valid = 1'b0;
    chk("mfhi wb_data", 64'(wb_data), 64'd1);
    chk("mfhi wb_dest", 64'(wb_dest), 64'd4);
    wb_ready = 1'b1;
    cycle("mfhi_pop");
    chk("mflo wb_data", 64'(wb_data), 64'd2);
    chk("mflo wb_dest", 64'(wb_dest), 64'd5);
    cycle("mflo_pop");
    chk("mflo_pop wb_valid", 64'(wb_valid), 64'd0);

    // Backpressure: three adds against a stalled register file.
    wb_ready = 1'b0;
    issue(5'd3, 64'd1, 4'd1, "bp1");
    issue(5'd3, 64'd2, 4'd2, "bp2");
    chk("bp full in_ready", 64'(in_ready), 64'd0);
    issue(5'd3, 64'd3, 4'd3, "bp3_held");
    chk("bp3_held z_out", z_out, 64'd2);
    wb_ready = 1'b1;
    cycle("bp_drain1");
    chk("bp_drain1 wb_data", 64'(wb_data), 64'd2);
    cycle("bp_accept3");
    chk("bp_accept3 wb_data", 64'(wb_data), 64'd3);
    in_valid = 1'b0;
    cycle("bp_drain3");
    chk("bp_drain3 wb_valid", 64'(wb_valid), 64'd0);

    // Halt with one entry queued.
    wb_ready = 1'b0;
    issue(5'd3, 64'd9, 4'd6, "pre_halt");
    issue(5'd26, 64'h1234, 4'd0, "halt");
    chk("halt halted", 64'(halted), 64'd1);
    chk("halt in_ready", 64'(in_ready), 64'd0);
    chk("halt wb_valid", 64'(wb_valid), 64'd1);
    issue(5'd13, 64'd77, 4'd7, "ori_ignored");
    chk("ori_ignored z_out", z_out, 64'h1234);
    chk("ori_ignored wb_data", 64'(wb_data), 64'd9);
    wb_ready = 1'b1;
    cycle("halt_drain");
    chk("halt_drain wb_valid", 64'(wb_valid), 64'd0);
    chk("halt_drain halted", 64'(halted), 64'd1);
    in_valid = 1'b0;
    clear = 1'b0;
    #1;
    chk("halt_clear halted", 64'(halted), 64'd0);
    chk("halt_clear in_ready", 64'(in_ready), 64'd1);
    clear = 1'b1;
    model_reset();

    // Asynchronous reset with a full queue and HI=7.
    wb_ready = 1'b0;
    issue(5'd14, {32'd7, 32'd8}, 4'd0, "amul");
    issue(5'd3, 64'd10, 4'd1, "aq1");
    issue(5'd3, 64'd11, 4'd2, "aq2");
    in_valid = 1'b0;
    chk("aq hi_out", 64'(hi_out), 64'd7);
    chk("aq wb_valid", 64'(wb_valid), 64'd1);
    #2;
    clear = 1'b0;
    #1;
    chk("async wb_valid", 64'(wb_valid), 64'd0);
    chk("async hi_out", 64'(hi_out), 64'd0);
    chk("async lo_out", 64'(lo_out), 64'd0);
    chk("async in_ready", 64'(in_ready), 64'd1);
    clear = 1'b1;
    model_reset();

    // Randomized traffic with occasional halts and asynchronous reset pulses.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] op;
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0) begin
        clear = 1'b0;
        #1;
        clear = 1'b1;
        model_reset();
      end
      op = 5'($urandom_range(0, 31));
      if (op == 5'd26 && $urandom_range(0, 7) != 0) op = 5'd3;
      in_valid = ($urandom_range(0, 9) < 7);
      opcode   = op;
      rc       = {$urandom, $urandom};
      in_dest  = 4'($urandom);
      wb_ready = ($urandom_range(0, 9) < 6);
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
